rf_wb_ctrl: RTL and testbench
=============================

Name: rf_wb_ctrl

Overview:
- Write-back controller on the write side of the 32x32 register file; sole driver of the RF write port (rd, write_e, write_d).
- Merges two result sources: single-cycle ALU results, which cannot be stalled, and load responses from the memory unit, buffered in an in-order FIFO.
- Keeps a pending-load scoreboard and reports RAW/WAW hazards to decode.

Parameters:
- DEPTH, 4, load-response FIFO entries; power of two, >= 2.
- XLEN, 32, data width.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- alu_valid  input  1  ALU result present this cycle; no backpressure.
- alu_rd  input  5  ALU destination register.
- alu_data  input  XLEN  ALU result.
- mem_valid  input  1  load response valid.
- mem_ready  output  1  FIFO can accept a response; equals !full.
- mem_rd  input  5  load destination register.
- mem_data  input  XLEN  load data.
- ld_issue  input  1  decode issues a load this cycle.
- ld_issue_rd  input  5  destination register of the issued load.
- rs1  input  5  decode source register 1.
- rs2  input  5  decode source register 2.
- dec_rd  input  5  decode destination register.
- hazard  output  1  decode must stall.
- rd  output  5  RF write address.
- write_e  output  1  RF write enable.
- write_d  output  XLEN  RF write data.
- pend_mask  output  32  scoreboard bits; bit 0 is always 0.

Behaviour:
- Reset (asynchronous on rst_n low, released synchronously to clk):
  - rd=0, write_e=0, write_d=0.
  - FIFO empty, so mem_ready=1.
  - pend_mask=0, hazard=0.
- Write port: rd, write_e and write_d are registered, so each RF write appears 1 cycle after the source event.
- Arbitration each cycle:
  - If alu_valid: the next cycle carries the ALU write; the FIFO does not pop.
  - Else if the FIFO is not empty: pop the head; the next cycle carries that load write.
  - Else: write_e=0 next cycle; rd and write_d hold their previous values.
- x0 suppression: a selected source with destination 0 still consumes (the FIFO pops) but produces write_e=0.
- FIFO:
  - Push when mem_valid && mem_ready.
  - When full, mem_ready=0 even if a pop occurs in the same cycle; no push-on-full.
  - Push into an empty FIFO is not popped in the same cycle (minimum load latency is 2 cycles from handshake to write_e).
  - Pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH. Full when the MSBs differ and the low bits are equal.
  - Strictly in-order.
- Scoreboard:
  - ld_issue with ld_issue_rd != 0 sets pend[ld_issue_rd].
  - A FIFO pop with head rd != 0 clears pend[head rd].
  - Set and clear of the same index in the same cycle: set wins.
  - ALU writes never clear pend bits.
- hazard (combinational): (rs1 != 0 && pend[rs1]) || (rs2 != 0 && pend[rs2]) || (dec_rd != 0 && pend[dec_rd]).
  - The dec_rd term blocks WAW with both ALU ops and loads, so at most one outstanding load exists per register.
- Reset mid-operation: FIFO contents and pend bits are discarded; no write_e is asserted after reset assertion.

Optional Feature:
- Macro: RF_WB_BYPASS_EN.
- When defined, adds outputs fwd1_valid, fwd1_data, fwd2_valid, fwd2_data (1/XLEN each).
  - fwdN_valid = write_e && rd == rsN && rsN != 0; fwdN_data = write_d.
  - This covers the same-cycle RF write/read collision.
  - In the hazard term, pend[rsN] is ignored when it is being cleared by the pop in that same cycle.
- When undefined: the ports are absent, and hazard uses the raw pend bits only.

Test Plan:
- Reset then idle: rst_n low for 3 cycles -> write_e=0, rd=0, write_d=0, mem_ready=1, pend_mask=0.
- ALU write: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF for 1 cycle -> next cycle write_e=1, rd=5, write_d=0xDEADBEEF; then write_e=0.
- Load path with collision:
  - ld_issue with rd=7 -> pend_mask[7]=1.
  - rs1=7 -> hazard=1.
  - mem response (rd=7, data 0x1234) accepted in the same cycle as alu_valid (rd=3) -> cycle+1 writes x3; cycle+2 writes x7=0x1234 and clears pend_mask[7]; hazard drops to 0.
- FIFO full:
  - Hold alu_valid=1 and push DEPTH=4 responses -> mem_ready=0 after the 4th.
  - Drop alu_valid -> 4 writes in push order on consecutive cycles; mem_ready returns to 1 the cycle after the first pop.
- x0 handling:
  - alu_rd=0 with data 0xFFFFFFFF -> write_e stays 0.
  - ld_issue to rd 0 -> pend_mask unchanged.
  - Response to rd 0 -> pops with no write.
- Reset mid-operation: 3 entries queued and pend bits set, pulse rst_n low asynchronously between edges -> outputs clear immediately; no subsequent write_e; mem_ready=1.

Source files
------------

// File: rtl/rf_wb_ctrl_if.sv
// Signal bundle between decode/ALU/memory unit and the register-file write-back controller.
// Define RF_WB_BYPASS_EN to add the same-cycle forwarding outputs.
interface rf_wb_ctrl_if #(
  parameter int XLEN = 32
);
  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            mem_valid;
  logic            mem_ready;
  logic [4:0]      mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            ld_issue;
  logic [4:0]      ld_issue_rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      dec_rd;
  logic            hazard;
  logic [4:0]      rd;
  logic            write_e;
  logic [XLEN-1:0] write_d;
  logic [31:0]     pend_mask;
`ifdef RF_WB_BYPASS_EN
  logic            fwd1_valid;
  logic [XLEN-1:0] fwd1_data;
  logic            fwd2_valid;
  logic [XLEN-1:0] fwd2_data;
`endif

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    input  ld_issue, ld_issue_rd, rs1, rs2, dec_rd,
    output mem_ready, hazard, rd, write_e, write_d, pend_mask
`ifdef RF_WB_BYPASS_EN
    , output fwd1_valid, fwd1_data, fwd2_valid, fwd2_data
`endif
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    output ld_issue, ld_issue_rd, rs1, rs2, dec_rd,
    input  mem_ready, hazard, rd, write_e, write_d, pend_mask
`ifdef RF_WB_BYPASS_EN
    , input fwd1_valid, fwd1_data, fwd2_valid, fwd2_data
`endif
  );
endinterface

// File: rtl/rf_wb_ctrl.sv
// RF write-back controller: ALU results win over an in-order load FIFO; pending-load scoreboard drives hazard.
// Write port is registered (1 cycle); mem_ready = !full. Optional macro RF_WB_BYPASS_EN adds forwarding outputs.
module rf_wb_ctrl #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input logic         clk,
  input logic         rst_n,
  rf_wb_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [4:0]      fifo_rd_q  [DEPTH];
  logic [XLEN-1:0] fifo_dat_q [DEPTH];
  logic [AW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic            empty, full, push, pop;
  logic [4:0]      head_rd;
  logic [XLEN-1:0] head_dat;
  logic [31:0]     pend_q, pend_d, clr_mask, pend_src;
  logic            we_q, we_d;
  logic [4:0]      rd_q, rd_d;
  logic [XLEN-1:0] wd_q, wd_d;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // Pop decision sees only pre-edge occupancy, so a fresh push is never popped in the same cycle.
  assign push     = bus.mem_valid && !full;
  assign pop      = !bus.alu_valid && !empty;
  assign head_rd  = fifo_rd_q[rd_ptr_q[AW-1:0]];
  assign head_dat = fifo_dat_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_comb begin
    we_d = 1'b0;
    rd_d = rd_q;
    wd_d = wd_q;
    if (bus.alu_valid) begin
      we_d = (bus.alu_rd != 5'd0);
      rd_d = bus.alu_rd;
      wd_d = bus.alu_data;
    end else if (pop) begin
      we_d = (head_rd != 5'd0);
      rd_d = head_rd;
      wd_d = head_dat;
    end
  end

  // Clear is applied before set so a same-index set/clear leaves the bit set.
  always_comb begin
    clr_mask = '0;
    if (pop && head_rd != 5'd0) clr_mask[head_rd] = 1'b1;
    pend_d = pend_q & ~clr_mask;
    if (bus.ld_issue && bus.ld_issue_rd != 5'd0) pend_d[bus.ld_issue_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

`ifdef RF_WB_BYPASS_EN
  assign pend_src       = pend_q & ~clr_mask;
  assign bus.fwd1_valid = we_q && (rd_q == bus.rs1) && (bus.rs1 != 5'd0);
  assign bus.fwd1_data  = wd_q;
  assign bus.fwd2_valid = we_q && (rd_q == bus.rs2) && (bus.rs2 != 5'd0);
  assign bus.fwd2_data  = wd_q;
`else
  assign pend_src       = pend_q;
`endif

  assign bus.hazard = ((bus.rs1 != 5'd0) && pend_src[bus.rs1]) ||
                      ((bus.rs2 != 5'd0) && pend_src[bus.rs2]) ||
                      ((bus.dec_rd != 5'd0) && pend_q[bus.dec_rd]);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q[AW-1:0]]  <= bus.mem_rd;
      fifo_dat_q[wr_ptr_q[AW-1:0]] <= bus.mem_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      pend_q   <= '0;
      we_q     <= 1'b0;
      rd_q     <= '0;
      wd_q     <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      pend_q   <= pend_d;
      we_q     <= we_d;
      rd_q     <= rd_d;
      wd_q     <= wd_d;
    end
  end

  assign bus.mem_ready = !full;
  assign bus.pend_mask = pend_q;
  assign bus.write_e   = we_q;
  assign bus.rd        = rd_q;
  assign bus.write_d   = wd_q;
endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Directed bench for rf_wb_ctrl: queue/array reference model checked every cycle plus literal spot checks.
module tb_rf_wb_ctrl;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 1'b0;

  rf_wb_ctrl_if #(.XLEN(32)) bus ();
  rf_wb_ctrl #(.DEPTH(DEPTH), .XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk1(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of responses, a pending bit array, and the last write issued.
  typedef struct packed { logic [4:0] rd; logic [31:0] d; } ent_t;
  ent_t      q[$];
  bit [31:0] m_pend;
  bit        m_we;
  bit [4:0]  m_rd;
  bit [31:0] m_wd;
  bit        m_pop, m_push;
  ent_t      m_h;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_pend = '0; m_we = 1'b0; m_rd = '0; m_wd = '0;
    end else begin
      m_pop  = !bus.alu_valid && (q.size() > 0);
      m_push = bus.mem_valid && (q.size() < DEPTH);
      if (bus.alu_valid) begin
        m_we = (bus.alu_rd != 0); m_rd = bus.alu_rd; m_wd = bus.alu_data;
      end else if (m_pop) begin
        m_h = q.pop_front();
        m_we = (m_h.rd != 0); m_rd = m_h.rd; m_wd = m_h.d;
        if (m_h.rd != 0) m_pend[m_h.rd] = 1'b0;
      end else begin
        m_we = 1'b0;
      end
      if (bus.ld_issue && bus.ld_issue_rd != 0) m_pend[bus.ld_issue_rd] = 1'b1;
      if (m_push) q.push_back({bus.mem_rd, bus.mem_data});
    end
  end

  function automatic bit src_pending(input logic [4:0] r);
    bit p;
    p = (r != 0) && m_pend[r];
`ifdef RF_WB_BYPASS_EN
    if (!bus.alu_valid && q.size() > 0 && q[0].rd == r) p = 1'b0;
`endif
    return p;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk1("write_e", bus.write_e, m_we);
      if (m_we) begin
        chk32("rd", {27'b0, bus.rd}, {27'b0, m_rd});
        chk32("write_d", bus.write_d, m_wd);
      end
      chk1("mem_ready", bus.mem_ready, q.size() < DEPTH);
      chk32("pend_mask", bus.pend_mask, m_pend);
      chk1("hazard", bus.hazard, src_pending(bus.rs1) || src_pending(bus.rs2) ||
                                 ((bus.dec_rd != 0) && m_pend[bus.dec_rd]));
`ifdef RF_WB_BYPASS_EN
      chk1("fwd1_valid", bus.fwd1_valid, m_we && m_rd == bus.rs1 && bus.rs1 != 0);
      chk1("fwd2_valid", bus.fwd2_valid, m_we && m_rd == bus.rs2 && bus.rs2 != 0);
      if (bus.fwd1_valid) chk32("fwd1_data", bus.fwd1_data, m_wd);
      if (bus.fwd2_valid) chk32("fwd2_data", bus.fwd2_data, m_wd);
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
    bus.mem_valid = 0; bus.mem_rd = 0; bus.mem_data = 0;
    bus.ld_issue = 0; bus.ld_issue_rd = 0;
    bus.rs1 = 0; bus.rs2 = 0; bus.dec_rd = 0;

    tick(3);
    chk1("rst write_e", bus.write_e, 1'b0);
    chk32("rst rd", {27'b0, bus.rd}, 32'd0);
    chk32("rst write_d", bus.write_d, 32'd0);
    chk1("rst mem_ready", bus.mem_ready, 1'b1);
    chk32("rst pend_mask", bus.pend_mask, 32'd0);
    chk1("rst hazard", bus.hazard, 1'b0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick(1);

    bus.alu_valid = 1; bus.alu_rd = 5; bus.alu_data = 32'hDEADBEEF;
    tick(1);
    bus.alu_valid = 0;
    chk1("alu write_e", bus.write_e, 1'b1);
    chk32("alu rd", {27'b0, bus.rd}, 32'd5);
    chk32("alu write_d", bus.write_d, 32'hDEADBEEF);
    tick(1);
    chk1("alu idle write_e", bus.write_e, 1'b0);
    chk32("idle rd hold", {27'b0, bus.rd}, 32'd5);
    chk32("idle write_d hold", bus.write_d, 32'hDEADBEEF);

    bus.ld_issue = 1; bus.ld_issue_rd = 7;
    tick(1);
    bus.ld_issue = 0;
    chk32("ld pend7", bus.pend_mask, 32'h0000_0080);
    bus.rs1 = 7;
    #1 chk1("raw hazard", bus.hazard, 1'b1);
    bus.mem_valid = 1; bus.mem_rd = 7; bus.mem_data = 32'h1234;
    bus.alu_valid = 1; bus.alu_rd = 3; bus.alu_data = 32'h33;
    tick(1);
    bus.mem_valid = 0; bus.alu_valid = 0;
    chk32("collide alu rd", {27'b0, bus.rd}, 32'd3);
    chk1("collide alu we", bus.write_e, 1'b1);
    tick(1);
    chk1("load we", bus.write_e, 1'b1);
    chk32("load rd", {27'b0, bus.rd}, 32'd7);
    chk32("load data", bus.write_d, 32'h1234);
    chk32("load pend clr", bus.pend_mask, 32'd0);
    chk1("hazard drop", bus.hazard, 1'b0);
    bus.rs1 = 0;
    bus.dec_rd = 7;
    #1 chk1("no waw after clr", bus.hazard, 1'b0);
    bus.dec_rd = 0;

    bus.alu_valid = 1; bus.alu_rd = 1;
    for (int i = 0; i < 5; i++) begin
      bus.alu_data = 32'h100 + i;
      bus.mem_valid = 1; bus.mem_rd = 5'(10 + i); bus.mem_data = 32'hA0 + i;
      tick(1);
    end
    chk1("full mem_ready", bus.mem_ready, 1'b0);
    bus.mem_valid = 0; bus.alu_valid = 0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk1("drain we", bus.write_e, 1'b1);
      chk32("drain rd", {27'b0, bus.rd}, 32'(10 + i));
      chk32("drain data", bus.write_d, 32'hA0 + i);
      if (i == 0) chk1("ready after pop", bus.mem_ready, 1'b1);
    end
    tick(1);
    chk1("drain done", bus.write_e, 1'b0);

    bus.alu_valid = 1; bus.alu_rd = 0; bus.alu_data = 32'hFFFFFFFF;
    tick(1);
    bus.alu_valid = 0;
    chk1("x0 alu", bus.write_e, 1'b0);
    bus.ld_issue = 1; bus.ld_issue_rd = 0;
    tick(1);
    bus.ld_issue = 0;
    chk32("x0 ld_issue", bus.pend_mask, 32'd0);
    bus.mem_valid = 1; bus.mem_rd = 0; bus.mem_data = 32'h55;
    tick(1);
    bus.mem_rd = 9; bus.mem_data = 32'h99;
    tick(1);
    bus.mem_valid = 0;
    chk1("x0 pop no write", bus.write_e, 1'b0);
    tick(1);
    chk32("after x0 rd", {27'b0, bus.rd}, 32'd9);
    chk1("after x0 we", bus.write_e, 1'b1);

    bus.ld_issue = 1; bus.ld_issue_rd = 4;
    tick(1);
    bus.ld_issue_rd = 6;
    tick(1);
    bus.ld_issue = 0;
    bus.alu_valid = 1; bus.alu_rd = 2; bus.alu_data = 32'h22;
    for (int i = 0; i < 3; i++) begin
      bus.mem_valid = 1; bus.mem_rd = 5'(4 + 2 * i); bus.mem_data = 32'hC0 + i;
      tick(1);
    end
    bus.mem_valid = 0;
    chk32("pre-reset pend", bus.pend_mask, 32'h0000_0050);
    chk1("pre-reset we", bus.write_e, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk1("mid rst write_e", bus.write_e, 1'b0);
    chk32("mid rst rd", {27'b0, bus.rd}, 32'd0);
    chk32("mid rst write_d", bus.write_d, 32'd0);
    chk1("mid rst mem_ready", bus.mem_ready, 1'b1);
    chk32("mid rst pend", bus.pend_mask, 32'd0);
    bus.alu_valid = 0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk1("post rst no write", bus.write_e, 1'b0);
    end
    chk1("post rst mem_ready", bus.mem_ready, 1'b1);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
